// File: rtl/dmem_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM state
// encodings, port identifiers and default bus widths.
package dmem_pkg;

   localparam int DMEM_AW = 32;
   localparam int DMEM_DW = 32;

   localparam logic PORT_0 = 1'b0;
   localparam logic PORT_1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } dmem_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// port that was not served most recently.
module rr_arb2
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_port,
   output logic       gnt_valid,
   output logic       gnt_id
);

   // Choose the winner from the request vector and the last-served port
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = PORT_0;
      case (req)
         2'b01: begin
            gnt_valid = 1'b1;
            gnt_id    = PORT_0;
         end
         2'b10: begin
            gnt_valid = 1'b1;
            gnt_id    = PORT_1;
         end
         2'b11: begin
            gnt_valid = 1'b1;
            gnt_id    = ~last_port;
         end
         default: begin
            gnt_valid = 1'b0;
            gnt_id    = PORT_0;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between two load/store requesters.
// One transaction is in flight at a time; the fixed memory read latency is
// absorbed by a down-counter and every output is registered.
module data_mem_arbiter
   import dmem_pkg::*;
#(
   parameter int AW     = DMEM_AW,
   parameter int DW     = DMEM_DW,
   parameter int RD_LAT = 1
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    Req,
   input  logic [1:0]    Wr,
   input  logic [AW-1:0] Address0,
   input  logic [AW-1:0] Address1,
   input  logic [DW-1:0] Write_data0,
   input  logic [DW-1:0] Write_data1,
   output logic [1:0]    Done,
   output logic [DW-1:0] Read_data,
   output logic [AW-1:0] Mem_Address,
   output logic [DW-1:0] Mem_Write_data,
   output logic          Mem_Write,
   output logic          Mem_Read,
   input  logic [DW-1:0] Mem_Read_data
);

   // Counter preload so the last WAIT cycle lines up with read data valid
   localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

   dmem_state_e   state_r;
   logic          winner_r;
   logic          last_r;
   logic          wr_r;
   logic [3:0]    cnt_r;

   logic          gnt_valid_s;
   logic          gnt_id_s;
   logic          sel_wr_s;
   logic [AW-1:0] sel_addr_s;
   logic [DW-1:0] sel_wdata_s;

   rr_arb2 u_arb (
      .req       (Req),
      .last_port (last_r),
      .gnt_valid (gnt_valid_s),
      .gnt_id    (gnt_id_s)
   );

   // Steer the granted port's command fields toward the latch registers
   always_comb begin
      sel_wr_s    = Wr[0];
      sel_addr_s  = Address0;
      sel_wdata_s = Write_data0;
      if (gnt_id_s == PORT_1) begin
         sel_wr_s    = Wr[1];
         sel_addr_s  = Address1;
         sel_wdata_s = Write_data1;
      end else begin
         sel_wr_s    = Wr[0];
         sel_addr_s  = Address0;
         sel_wdata_s = Write_data0;
      end
   end

   // Transaction FSM: arbitrate, issue one strobe, wait out read latency, respond
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         winner_r       <= PORT_0;
         last_r         <= PORT_1;
         wr_r           <= 1'b0;
         cnt_r          <= 4'd0;
         Done           <= 2'b00;
         Read_data      <= '0;
         Mem_Address    <= '0;
         Mem_Write_data <= '0;
         Mem_Write      <= 1'b0;
         Mem_Read       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               Done <= 2'b00;
               if (gnt_valid_s) begin
                  winner_r       <= gnt_id_s;
                  last_r         <= gnt_id_s;
                  wr_r           <= sel_wr_s;
                  Mem_Address    <= sel_addr_s;
                  Mem_Write_data <= sel_wdata_s;
                  Mem_Write      <= sel_wr_s;
                  Mem_Read       <= ~sel_wr_s;
                  state_r        <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               Mem_Write <= 1'b0;
               Mem_Read  <= 1'b0;
               if (wr_r) begin
                  Done[winner_r] <= 1'b1;
                  state_r        <= ST_RESP;
               end else begin
                  cnt_r   <= CNT_LOAD;
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_r == 4'd0) begin
                  Read_data      <= Mem_Read_data;
                  Done[winner_r] <= 1'b1;
                  state_r        <= ST_RESP;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_RESP: begin
               Done    <= 2'b00;
               state_r <= ST_IDLE;
            end
            default: begin
               Done      <= 2'b00;
               Mem_Write <= 1'b0;
               Mem_Read  <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised self-checking bench for data_mem_arbiter. A transaction-level
// reference model predicts grants, Done timing, strobes and read data.
module tb_data_mem_arbiter;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int RD_LAT = 3;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    Req;
   logic [1:0]    Wr;
   logic [AW-1:0] Address0;
   logic [AW-1:0] Address1;
   logic [DW-1:0] Write_data0;
   logic [DW-1:0] Write_data1;
   logic [1:0]    Done;
   logic [DW-1:0] Read_data;
   logic [AW-1:0] Mem_Address;
   logic [DW-1:0] Mem_Write_data;
   logic          Mem_Write;
   logic          Mem_Read;
   logic [DW-1:0] Mem_Read_data;

   data_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk            (clk),
      .reset          (reset),
      .Req            (Req),
      .Wr             (Wr),
      .Address0       (Address0),
      .Address1       (Address1),
      .Write_data0    (Write_data0),
      .Write_data1    (Write_data1),
      .Done           (Done),
      .Read_data      (Read_data),
      .Mem_Address    (Mem_Address),
      .Mem_Write_data (Mem_Write_data),
      .Mem_Write      (Mem_Write),
      .Mem_Read       (Mem_Read),
      .Mem_Read_data  (Mem_Read_data)
   );

   always #5 clk = ~clk;

   // Environment memory: 64 words, synchronous write, read data after RD_LAT cycles
   logic [DW-1:0] tb_mem  [64]     = '{default: '0};
   logic [DW-1:0] rd_pipe [RD_LAT] = '{default: '0};

   always @(posedge clk) begin
      if (Mem_Write) tb_mem[Mem_Address[5:0]] <= Mem_Write_data;
      if (Mem_Read) rd_pipe[0] <= tb_mem[Mem_Address[5:0]];
      else          rd_pipe[0] <= $urandom();
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign Mem_Read_data = rd_pipe[RD_LAT-1];

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: transaction-level view (remaining cycles, age in txn)
   logic [DW-1:0] m_mem [64] = '{default: '0};
   int            m_left = 0;
   int            m_age  = 0;
   logic          m_win  = 1'b0;
   logic          m_last = 1'b1;
   logic          m_wr   = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic [DW-1:0] m_pend = '0;
   logic [DW-1:0] m_rdata = '0;
   logic [1:0]    e_done = 2'b00;
   logic          e_mw = 1'b0;
   logic          e_mr = 1'b0;
   logic          e_zero_bus = 1'b0;

   // Requester behaviour
   txn_t q0[$];
   txn_t q1[$];
   txn_t d_txn [2];
   logic [1:0] d_pend = 2'b00;
   logic [1:0] d_req  = 2'b00;
   bit   rand_on = 1'b0;
   int   req_pct = 0;
   int   drop_pct = 0;
   bit   reset_in_wait = 1'b0;

   function automatic txn_t rand_txn();
      txn_t t;
      t.wr   = 1'($urandom_range(1));
      t.addr = $urandom();
      t.data = $urandom();
      return t;
   endfunction

   // One clock cycle: check outputs, drive requests, advance the model
   task automatic step();
      bit   rst_now;
      bit   have;
      txn_t t;
      check_val("done",      32'(Done),      32'(e_done));
      check_val("mem_write", 32'(Mem_Write), 32'(e_mw));
      check_val("mem_read",  32'(Mem_Read),  32'(e_mr));
      check_val("read_data", Read_data,      m_rdata);
      if (e_mw || e_mr) check_val("mem_addr", Mem_Address, m_addr);
      if (e_mw) check_val("mem_wdata", Mem_Write_data, m_data);
      if (e_zero_bus) begin
         check_val("rst_addr",  Mem_Address,    32'd0);
         check_val("rst_wdata", Mem_Write_data, 32'd0);
      end

      for (int p = 0; p < 2; p++) begin
         if (e_done[p]) d_pend[p] = 1'b0;
         if (!d_pend[p]) begin
            have = 1'b0;
            if (p == 0 && q0.size() > 0) begin t = q0.pop_front(); have = 1'b1; end
            else if (p == 1 && q1.size() > 0) begin t = q1.pop_front(); have = 1'b1; end
            else if (rand_on && $urandom_range(99) < req_pct) begin t = rand_txn(); have = 1'b1; end
            if (have) begin
               d_txn[p]  = t;
               d_pend[p] = 1'b1;
               d_req[p]  = 1'b1;
            end else begin
               d_txn[p] = rand_txn();
               d_req[p] = 1'b0;
            end
         end else if (m_left > 0 && m_win == 1'(p)) begin
            if ($urandom_range(99) < drop_pct) d_req[p] = 1'b0;
         end else begin
            d_req[p] = 1'b1;
         end
      end
      Req         = d_req;
      Wr          = {d_txn[1].wr, d_txn[0].wr};
      Address0    = d_txn[0].addr;
      Address1    = d_txn[1].addr;
      Write_data0 = d_txn[0].data;
      Write_data1 = d_txn[1].data;

      rst_now = reset_in_wait && m_left > 0 && !m_wr && m_age == 2;
      reset   = rst_now;

      if (rst_now) begin
         reset_in_wait = 1'b0;
         m_left = 0; m_age = 0; m_last = 1'b1; m_rdata = '0;
         e_done = 2'b00; e_mw = 1'b0; e_mr = 1'b0; e_zero_bus = 1'b1;
      end else begin
         e_zero_bus = 1'b0;
         if (m_left == 0 && Req != 2'b00) begin
            if (Req == 2'b01)      m_win = 1'b0;
            else if (Req == 2'b10) m_win = 1'b1;
            else                   m_win = ~m_last;
            m_last = m_win;
            m_wr   = d_txn[m_win].wr;
            m_addr = d_txn[m_win].addr;
            m_data = d_txn[m_win].data;
            if (m_wr) m_mem[m_addr[5:0]] = m_data;
            else      m_pend = m_mem[m_addr[5:0]];
            m_left = m_wr ? 3 : 3 + RD_LAT;
            m_age  = 0;
         end
         if (m_left > 0) begin
            m_left--;
            m_age++;
         end
         e_done = (m_left == 1) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
         if (m_left == 1 && !m_wr) m_rdata = m_pend;
         e_mw = (m_left > 0) && (m_age == 1) && m_wr;
         e_mr = (m_left > 0) && (m_age == 1) && !m_wr;
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      reset = 1'b1;
      Req = 2'b00; Wr = 2'b00;
      Address0 = '0; Address1 = '0; Write_data0 = '0; Write_data1 = '0;
      d_txn[0] = '0; d_txn[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_done",  32'(Done),      32'd0);
      check_val("rst_rdata", Read_data,      32'd0);
      check_val("rst_maddr", Mem_Address,    32'd0);
      check_val("rst_mwd",   Mem_Write_data, 32'd0);
      check_val("rst_mw",    32'(Mem_Write), 32'd0);
      check_val("rst_mr",    32'(Mem_Read),  32'd0);

      // write then read back through port 0
      q0.push_back('{wr: 1'b1, addr: 32'd5, data: 32'hDEADBEEF});
      q0.push_back('{wr: 1'b0, addr: 32'd5, data: 32'd0});
      run(20);

      // both ports saturating with reads
      for (int i = 0; i < 4; i++) begin
         q0.push_back('{wr: 1'b0, addr: 32'd0, data: 32'd0});
         q1.push_back('{wr: 1'b0, addr: 32'd1, data: 32'd0});
      end
      run(60);

      // only port 1 active
      for (int i = 0; i < 4; i++) q1.push_back('{wr: 1'(i % 2), addr: 32'(40 + i), data: 32'(i * 7)});
      run(40);

      // place 3 at address 21 then read it back
      q0.push_back('{wr: 1'b1, addr: 32'd21, data: 32'd3});
      q0.push_back('{wr: 1'b0, addr: 32'd21, data: 32'd0});
      run(20);

      // reset during WAIT, then both requesters re-present
      reset_in_wait = 1'b1;
      q0.push_back('{wr: 1'b0, addr: 32'd5, data: 32'd0});
      q1.push_back('{wr: 1'b0, addr: 32'd21, data: 32'd0});
      run(40);

      // requester drops Req right after grant
      drop_pct = 100;
      q0.push_back('{wr: 1'b1, addr: 32'd9, data: 32'hA5A5_0009});
      q0.push_back('{wr: 1'b0, addr: 32'd9, data: 32'd0});
      run(20);

      // random traffic
      drop_pct = 15;
      req_pct  = 40;
      rand_on  = 1'b1;
      run(2000);
      req_pct  = 90;
      run(1000);
      rand_on  = 1'b0;
      drop_pct = 0;
      run(30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
